// File: rtl/jtkcpu_pcseq.sv
// Program-counter sequencer: increment, relative branches, jumps, loads and a
// circular return stack for call/ret with sticky overflow/underflow flags.
module jtkcpu_pcseq #(
  parameter int unsigned    AW    = 16,
  parameter int unsigned    DEPTH = 4,
  parameter logic [AW-1:0]  RSTV  = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic          inc,
  input  logic          br8,
  input  logic          br16,
  input  logic          cond,
  input  logic          jmp,
  input  logic          call,
  input  logic          ret,
  input  logic          ld,
  input  logic [AW-1:0] mdata,
  input  logic [AW-1:0] jaddr,
  output logic [AW-1:0] pc,
  output logic          bdone,
  output logic          rs_full,
  output logic          rs_empty,
  output logic          rs_ovf,
  output logic          rs_udf
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [AW-1:0] pc_q, pc_d;
  logic          bdone_q, bdone_d;
  logic [PW-1:0] wp_q, wp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic [AW-1:0] stk_q [DEPTH];

  logic          br_req;
  logic          br_take;
  logic          push;
  logic [PW-1:0] top_idx;
  logic [AW-1:0] off8;

  // Branch qualification and sign-extended short offset
  always_comb begin
    br_req  = (br8 | br16) & cond;
    br_take = br_req & ~bdone_q;
    top_idx = wp_q - PW'(1);
    off8    = AW'($signed(mdata[7:0]));
  end

  assign rs_full  = (cnt_q == CW'(DEPTH));
  assign rs_empty = (cnt_q == CW'(0));

  // Next-state selection with fixed source priority
  always_comb begin
    pc_d    = pc_q;
    bdone_d = br_req;
    wp_d    = wp_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    push    = 1'b0;
    if (inc) begin
      pc_d = pc_q + AW'(1);
    end else if (br_take && br8) begin
      pc_d = pc_q + off8;
    end else if (br_take && br16) begin
      pc_d = pc_q + mdata;
    end else if (call) begin
      push = 1'b1;
      pc_d = jaddr;
      wp_d = wp_q + PW'(1);
      if (rs_full) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else if (jmp) begin
      pc_d = jaddr;
    end else if (ret) begin
      if (rs_empty) begin
        udf_d = 1'b1;
      end else begin
        pc_d  = stk_q[top_idx];
        wp_d  = top_idx;
        cnt_d = cnt_q - CW'(1);
      end
    end else if (ld) begin
      pc_d = mdata;
    end
  end

  // Control state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RSTV;
      bdone_q <= 1'b0;
      wp_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else if (cen) begin
      pc_q    <= pc_d;
      bdone_q <= bdone_d;
      wp_q    <= wp_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Return-stack storage; contents are not reset, only the pointers are
  always_ff @(posedge clk) begin
    if (!rst && cen && push) begin
      stk_q[wp_q] <= pc_q;
    end
  end

  assign pc     = pc_q;
  assign bdone  = bdone_q;
  assign rs_ovf = ovf_q;
  assign rs_udf = udf_q;

endmodule

// File: tb/tb_jtkcpu_pcseq.sv
// Bench for jtkcpu_pcseq: directed scenarios plus random traffic against a
// queue-based reference model.
module tb_jtkcpu_pcseq;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, cen, inc, br8, br16, cond, jmp, call, ret, ld;
  logic [15:0] mdata, jaddr;
  logic [15:0] pc;
  logic        bdone, rs_full, rs_empty, rs_ovf, rs_udf;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int          m_pc;
  bit          m_bdone, m_ovf, m_udf;
  logic [15:0] m_stack [$];

  jtkcpu_pcseq #(.AW(16), .DEPTH(DEPTH), .RSTV(16'h0000)) dut (
    .clk(clk), .rst(rst), .cen(cen), .inc(inc), .br8(br8), .br16(br16),
    .cond(cond), .jmp(jmp), .call(call), .ret(ret), .ld(ld),
    .mdata(mdata), .jaddr(jaddr), .pc(pc), .bdone(bdone),
    .rs_full(rs_full), .rs_empty(rs_empty), .rs_ovf(rs_ovf), .rs_udf(rs_udf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rst = 0; cen = 1; inc = 0; br8 = 0; br16 = 0; cond = 0;
    jmp = 0; call = 0; ret = 0; ld = 0; mdata = '0; jaddr = '0;
  endtask

  // Apply the spec rules to the model using the inputs present before the edge
  task automatic model_step();
    bit req, take;
    int off;
    if (rst) begin
      m_pc = 0; m_bdone = 0; m_ovf = 0; m_udf = 0;
      m_stack.delete();
    end else if (cen) begin
      req  = (br8 || br16) && cond;
      take = req && !m_bdone;
      if (inc) m_pc = (m_pc + 1) % 65536;
      else if (take && br8) begin
        off  = int'(mdata[7:0]);
        if (off >= 128) off -= 256;
        m_pc = (m_pc + off + 65536) % 65536;
      end else if (take && br16) m_pc = (m_pc + int'(mdata)) % 65536;
      else if (call) begin
        m_stack.push_back(16'(m_pc));
        if (m_stack.size() > DEPTH) begin
          void'(m_stack.pop_front());
          m_ovf = 1;
        end
        m_pc = int'(jaddr);
      end else if (jmp) m_pc = int'(jaddr);
      else if (ret) begin
        if (m_stack.size() > 0) m_pc = int'(m_stack.pop_back());
        else m_udf = 1;
      end else if (ld) m_pc = int'(mdata);
      m_bdone = req;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_pc"},    32'(pc),       32'(m_pc));
    chk({tag, "_bdone"}, 32'(bdone),    32'(m_bdone));
    chk({tag, "_full"},  32'(rs_full),  32'(m_stack.size() == DEPTH));
    chk({tag, "_empty"}, 32'(rs_empty), 32'(m_stack.size() == 0));
    chk({tag, "_ovf"},   32'(rs_ovf),   32'(m_ovf));
    chk({tag, "_udf"},   32'(rs_udf),   32'(m_udf));
  endtask

  task automatic cyc(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  initial begin
    idle();
    #2;
    // reset
    rst = 1; cyc("rst");
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_empty", 32'(rs_empty), 32'h1);

    // short backward branch held three cycles applies once
    idle(); jmp = 1; jaddr = 16'h10FE; cyc("b8_setup");
    idle(); br8 = 1; cond = 1; mdata = 16'h00F0;
    cyc("b8_c1"); chk("b8_pc1", 32'(pc), 32'h10EE);
    cyc("b8_c2"); chk("b8_pc2", 32'(pc), 32'h10EE); chk("b8_bd2", 32'(bdone), 32'h1);
    cyc("b8_c3"); chk("b8_pc3", 32'(pc), 32'h10EE); chk("b8_bd3", 32'(bdone), 32'h1);

    // increment wrap and priority over br16/jmp
    idle(); jmp = 1; jaddr = 16'hFFFF; cyc("inc_setup");
    idle(); inc = 1; cyc("inc_wrap"); chk("inc_wrap_pc", 32'(pc), 32'h0);
    idle(); jmp = 1; jaddr = 16'hFFFF; cyc("inc_setup2");
    idle(); inc = 1; br16 = 1; cond = 1; mdata = 16'h0100; jmp = 1; jaddr = 16'h5555;
    cyc("inc_prio"); chk("inc_prio_pc", 32'(pc), 32'h0);

    // call then ret
    idle(); jmp = 1; jaddr = 16'h1234; cyc("cr_setup");
    idle(); call = 1; jaddr = 16'h8000; cyc("cr_call"); chk("cr_call_pc", 32'(pc), 32'h8000);
    idle(); ret = 1; cyc("cr_ret"); chk("cr_ret_pc", 32'(pc), 32'h1234);
    chk("cr_empty", 32'(rs_empty), 32'h1);

    // overflow and underflow
    idle(); rst = 1; cyc("ov_rst");
    idle(); jmp = 1; jaddr = 16'h0100; cyc("ov_setup");
    for (int i = 0; i < 5; i++) begin
      idle(); call = 1; jaddr = 16'((i + 2) * 16'h0100); cyc("ov_call");
    end
    chk("ov_ovf", 32'(rs_ovf), 32'h1);
    chk("ov_full", 32'(rs_full), 32'h1);
    for (int i = 0; i < 4; i++) begin
      idle(); ret = 1; cyc("ov_ret");
      chk("ov_ret_pc", 32'(pc), 32'((5 - i) * 16'h0100));
    end
    idle(); ret = 1; cyc("ud_ret");
    chk("ud_pc", 32'(pc), 32'h0200);
    chk("ud_udf", 32'(rs_udf), 32'h1);

    // clock enable low ignores everything; reset beats call
    idle(); call = 1; jaddr = 16'h4444; cyc("ce_setup");
    idle(); cen = 0; inc = 1; br8 = 1; br16 = 1; cond = 1; jmp = 1; call = 1;
    ret = 1; ld = 1; mdata = 16'h0077; jaddr = 16'h9999;
    cyc("ce_hold"); chk("ce_pc", 32'(pc), 32'h4444);
    idle(); rst = 1; call = 1; jaddr = 16'h7777; cyc("rc");
    chk("rc_pc", 32'(pc), 32'h0); chk("rc_empty", 32'(rs_empty), 32'h1);
    chk("rc_ovf", 32'(rs_ovf), 32'h0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      idle();
      rst   = ($urandom_range(0, 63) == 0);
      cen   = ($urandom_range(0, 7) != 0);
      inc   = ($urandom_range(0, 5) == 0);
      br8   = ($urandom_range(0, 3) == 0);
      br16  = ($urandom_range(0, 4) == 0);
      cond  = ($urandom_range(0, 2) != 0);
      jmp   = ($urandom_range(0, 5) == 0);
      call  = ($urandom_range(0, 2) == 0);
      ret   = ($urandom_range(0, 2) == 0);
      ld    = ($urandom_range(0, 4) == 0);
      mdata = 16'($urandom);
      jaddr = 16'($urandom);
      cyc("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
